// File: rtl/vga_framebuffer_scanout.sv
// 640x480@60 VGA scan-out for a 320x240x3 frame buffer read through a synchronous port.
// Every buffer pixel is doubled horizontally and vertically. Sync, blank and colour leave together.
module vga_framebuffer_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clock,
  input  logic        resetn,
  output logic [16:0] mem_addr,
  input  logic [2:0]  mem_q,
  output logic        frame_start,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B
);

  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic        pix_en_q, vga_clk_q;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [16:0] mem_addr_q, mem_addr_d;
  logic        frame_start_q, frame_start_d;
  logic        hs1_q, vs1_q, blank1_q;
  logic        hs_q, vs_q, blank_n_q;
  logic [2:0]  rgb_q, rgb_d;
  logic        visible, hs_n, vs_n;
  logic [8:0]  ya, xa;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Address y*320 + x built as y*256 + y*64 + x on the halved counters.
  always_comb begin
    visible       = (h_q < H_VIS) && (v_q < V_VIS);
    hs_n          = !((h_q >= HS_BEG) && (h_q < HS_END));
    vs_n          = !((v_q >= VS_BEG) && (v_q < VS_END));
    ya            = v_q[9:1];
    xa            = h_q[9:1];
    mem_addr_d    = visible ? ({ya, 8'd0} + {2'd0, ya, 6'd0} + {8'd0, xa}) : 17'd0;
    frame_start_d = pix_en_q && (h_q == H_LAST) && (v_q == V_LAST);
    rgb_d         = blank1_q ? 3'b000 : mem_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pix_en_q      <= 1'b0;
      vga_clk_q     <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      mem_addr_q    <= '0;
      frame_start_q <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      blank1_q      <= 1'b1;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      rgb_q         <= '0;
    end else begin
      pix_en_q      <= ~pix_en_q;
      vga_clk_q     <= ~pix_en_q;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= frame_start_d;
      // Stage 1 captures the current pixel while stage 2 emits the previous one with its buffer data.
      if (pix_en_q) begin
        mem_addr_q <= mem_addr_d;
        hs1_q      <= hs_n;
        vs1_q      <= vs_n;
        blank1_q   <= !visible;
        hs_q       <= hs1_q;
        vs_q       <= vs1_q;
        blank_n_q  <= !blank1_q;
        rgb_q      <= rgb_d;
      end
    end
  end

  assign mem_addr    = mem_addr_q;
  assign frame_start = frame_start_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = {10{rgb_q[2]}};
  assign VGA_G       = {10{rgb_q[1]}};
  assign VGA_B       = {10{rgb_q[0]}};

endmodule

// File: tb/tb_vga_framebuffer_scanout.sv
// Bench for vga_framebuffer_scanout: a full-size instance for line timing and addressing,
// and a shrunken-timing instance so whole frames and mid-frame reset fit in a short run.
module tb_vga_framebuffer_scanout;

  localparam int SH_VIS = 16, SH_FP = 4, SH_SW = 6, SH_BP = 4;
  localparam int SV_VIS = 12, SV_FP = 2, SV_SW = 2, SV_BP = 3;
  localparam int S_FRAME = (SH_VIS + SH_FP + SH_SW + SH_BP) * (SV_VIS + SV_FP + SV_SW + SV_BP) * 2;

  typedef struct packed {
    logic [16:0] addr;
    logic        fs;
    logic        vclk;
    logic        hs;
    logic        vs;
    logic        bn;
    logic        sync_n;
    logic [9:0]  r;
    logic [9:0]  g;
    logic [9:0]  b;
  } out_t;

  typedef struct {
    int          h;
    int          v;
    logic [16:0] addr;
  } addr_vec_t;

  localparam out_t RST = '{addr: 17'd0, fs: 1'b0, vclk: 1'b0, hs: 1'b1, vs: 1'b1,
                           bn: 1'b0, sync_n: 1'b0, r: 10'd0, g: 10'd0, b: 10'd0};

  logic        clk = 1'b0;
  logic        rst_f = 1'b0, rst_s = 1'b0;
  logic [16:0] mem_addr_f, mem_addr_s;
  logic [2:0]  mem_q_f = 3'd0, mem_q_s = 3'd0;
  logic        fs_f, fs_s, vclk_f, vclk_s, hs_f, hs_s, vs_f, vs_s, bn_f, bn_s, sn_f, sn_s;
  logic [9:0]  r_f, g_f, b_f, r_s, g_s, b_s;
  out_t        act_f, act_s;

  logic [2:0]  fb [0:76799];
  int          k_f, k_s;
  int          n_chk = 0, n_err = 0;
  bit          chk_en = 0, small_done = 0;
  int          hs_fall_f[$], hs_rise_f[$], vs_fall_s[$], vs_rise_s[$], fs_k_s[$];
  int          bn_cnt_f = 0;
  logic [29:0] rgb_at8 = '0, rgb_at1404 = '1;
  logic        prev_hs_f = 1'b1, prev_vs_s = 1'b1;

  always #10 clk = ~clk;

  vga_framebuffer_scanout dut_f (
    .clock(clk), .resetn(rst_f), .mem_addr(mem_addr_f), .mem_q(mem_q_f), .frame_start(fs_f),
    .VGA_CLK(vclk_f), .VGA_HS(hs_f), .VGA_VS(vs_f), .VGA_BLANK_N(bn_f), .VGA_SYNC_N(sn_f),
    .VGA_R(r_f), .VGA_G(g_f), .VGA_B(b_f));

  vga_framebuffer_scanout #(
    .H_VISIBLE(SH_VIS), .H_FRONT(SH_FP), .H_SYNC(SH_SW), .H_BACK(SH_BP),
    .V_VISIBLE(SV_VIS), .V_FRONT(SV_FP), .V_SYNC(SV_SW), .V_BACK(SV_BP)
  ) dut_s (
    .clock(clk), .resetn(rst_s), .mem_addr(mem_addr_s), .mem_q(mem_q_s), .frame_start(fs_s),
    .VGA_CLK(vclk_s), .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(bn_s), .VGA_SYNC_N(sn_s),
    .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s));

  assign act_f = {mem_addr_f, fs_f, vclk_f, hs_f, vs_f, bn_f, sn_f, r_f, g_f, b_f};
  assign act_s = {mem_addr_s, fs_s, vclk_s, hs_s, vs_s, bn_s, sn_s, r_s, g_s, b_s};

  // Synchronous-read frame buffer ports.
  always @(posedge clk) mem_q_f <= fb[mem_addr_f];
  always @(posedge clk) mem_q_s <= fb[mem_addr_s];

  // Clock edges seen since reset release.
  always @(posedge clk or negedge rst_f) if (!rst_f) k_f <= 0; else k_f <= k_f + 1;
  always @(posedge clk or negedge rst_s) if (!rst_s) k_s <= 0; else k_s <= k_s + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic int pix_addr(int p, int hv, int vv, int ht, int vt);
    int q, h, v;
    q = p % (ht * vt);
    h = q % ht;
    v = q / ht;
    if (h < hv && v < vv) return (v / 2) * 320 + h / 2;
    return 0;
  endfunction

  // Expected pins after k edges: pixel n is fetched at edge 2(n+1) and shown at edge 2(n+2).
  function automatic out_t model(int k, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb);
    out_t o;
    int ht, vt, m, p, q, h, v, a;
    logic [2:0] c;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    o = RST;
    if (k == 0) return o;
    m = k / 2;
    o.vclk = (k % 2 == 1);
    if (m >= 1) begin
      p = m - 1;
      o.addr = 17'(pix_addr(p, hv, vv, ht, vt));
      o.fs = (k % 2 == 0) && (p % (ht * vt) == ht * vt - 1);
    end
    if (m >= 2) begin
      p = m - 2;
      q = p % (ht * vt);
      h = q % ht;
      v = q / ht;
      o.hs = !(h >= hv + hf && h < hv + hf + hsw);
      o.vs = !(v >= vv + vf && v < vv + vf + vsw);
      o.bn = (h < hv && v < vv);
      if (o.bn) begin
        a = pix_addr(p, hv, vv, ht, vt);
        c = fb[a];
        o.r = {10{c[2]}};
        o.g = {10{c[1]}};
        o.b = {10{c[0]}};
      end
    end
    return o;
  endfunction

  // Per-cycle model comparison and event capture, sampled away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check($sformatf("model_full k=%0d", k_f), act_f, model(k_f, 640, 16, 96, 48, 480, 10, 2, 33));
        check($sformatf("model_small k=%0d", k_s), act_s,
              model(k_s, SH_VIS, SH_FP, SH_SW, SH_BP, SV_VIS, SV_FP, SV_SW, SV_BP));
        if (prev_hs_f && !hs_f) hs_fall_f.push_back(k_f);
        if (!prev_hs_f && hs_f) hs_rise_f.push_back(k_f);
        if (k_f >= 3 && k_f <= 1602 && bn_f) bn_cnt_f++;
        if (k_f == 8) rgb_at8 = {r_f, g_f, b_f};
        if (k_f == 1404) rgb_at1404 = {r_f, g_f, b_f};
        if (prev_vs_s && !vs_s) vs_fall_s.push_back(k_s);
        if (!prev_vs_s && vs_s) vs_rise_s.push_back(k_s);
        if (fs_s) fs_k_s.push_back(k_s);
      end
      prev_hs_f = hs_f;
      prev_vs_s = vs_s;
    end
  end

  task automatic wait_k_f(input int target, input string name);
    int g = 0;
    while (k_f < target && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (k_f != target) begin
      n_chk++;
      n_err++;
      $display("FAIL %s timeout k=%0d want %0d", name, k_f, target);
    end
  endtask

  // Main sequence: reset, address table, line timing, colour/blank.
  initial begin
    addr_vec_t tbl[6];
    int g;
    tbl[0] = '{0,   0, 17'd0};
    tbl[1] = '{2,   0, 17'd1};
    tbl[2] = '{639, 0, 17'd319};
    tbl[3] = '{640, 0, 17'd0};
    tbl[4] = '{3,   1, 17'd1};
    tbl[5] = '{0,   2, 17'd320};

    for (int i = 0; i < 76800; i++) fb[i] = 3'($urandom);
    fb[0] = 3'b111;
    fb[1] = 3'b101;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_full", act_f, RST);
    check("reset_small", act_s, RST);
    rst_f = 1'b1;
    rst_s = 1'b1;
    chk_en = 1;

    for (int i = 0; i < 6; i++) begin
      wait_k_f(2 * (tbl[i].v * 800 + tbl[i].h + 1), "addr_wait");
      $display("vec %0d h=%0d v=%0d mem_addr=%0d", i, tbl[i].h, tbl[i].v, mem_addr_f);
      check($sformatf("addr h=%0d v=%0d", tbl[i].h, tbl[i].v), mem_addr_f, tbl[i].addr);
    end

    wait_k_f(4700, "line_wait");
    if (hs_fall_f.size() < 3 || hs_rise_f.size() < 1) begin
      n_chk++;
      n_err++;
      $display("FAIL hs_events got %0d falls want 3", hs_fall_f.size());
    end else begin
      check("hs_fall_line0", hs_fall_f[0], 1316);
      check("hs_fall_line1", hs_fall_f[1], 2916);
      check("hs_fall_line2", hs_fall_f[2], 4516);
      check("hs_low_width", hs_rise_f[0] - hs_fall_f[0], 192);
    end
    check("blank_n_high_per_line", bn_cnt_f, 1280);
    check("colour_101_visible", rgb_at8, {10'h3FF, 10'h000, 10'h3FF});
    check("colour_111_blanked", rgb_at1404, 30'd0);

    g = 0;
    while (!small_done && g < 10000) begin
      @(negedge clk);
      g++;
    end
    if (!small_done) begin
      n_chk++;
      n_err++;
      $display("FAIL small_seq timeout got 0 want 1");
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Frame-level sequence on the shrunken instance, including a random mid-frame reset.
  initial begin
    int pause;
    wait (chk_en);
    repeat (2 * S_FRAME + 10) @(posedge clk);
    @(negedge clk);
    if (fs_k_s.size() != 2 || vs_fall_s.size() < 2 || vs_rise_s.size() < 1) begin
      n_chk++;
      n_err++;
      $display("FAIL small_events got fs=%0d vsf=%0d want fs=2 vsf>=2", fs_k_s.size(), vs_fall_s.size());
    end else begin
      check("frame_start_first", fs_k_s[0], S_FRAME);
      check("frame_start_period", fs_k_s[1] - fs_k_s[0], S_FRAME);
      check("vs_fall_frame0", vs_fall_s[0], 2 * (14 * 30 + 2));
      check("vs_low_width", vs_rise_s[0] - vs_fall_s[0], 2 * 2 * 30);
      check("vs_fall_frame1", vs_fall_s[1] - vs_fall_s[0], S_FRAME);
    end

    pause = $urandom_range(50, 900);
    repeat (pause) @(posedge clk);
    #1 rst_s = 1'b0;
    #1 check("async_reset_small", act_s, RST);
    fs_k_s.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_s = 1'b1;
    repeat (S_FRAME + 10) @(posedge clk);
    @(negedge clk);
    if (fs_k_s.size() != 1) begin
      n_chk++;
      n_err++;
      $display("FAIL fs_after_reset got %0d pulses want 1", fs_k_s.size());
    end else begin
      check("fs_after_reset", fs_k_s[0], S_FRAME);
    end
    small_done = 1;
  end

endmodule
